divsqrt_qgen: RTL and testbench

//  Iterative radix-2 non-restoring mantissa divider that feeds the divide rounder.

---
 rtl/fpdiv_pkg.sv | 47 ++++
 rtl/divsqrt_qgen_if.sv | 37 +++
 rtl/nrdiv_step.sv | 24 ++
 rtl/divsqrt_qgen.sv | 156 +++++++++++++++
 tb/tb_divsqrt_qgen.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpdiv_pkg.sv
// fpdiv_pkg: shared widths, biases, FSM encoding and quotient-set helpers
// for the iterative mantissa divider.
package fpdiv_pkg;

  localparam int QW      = 65;   // raw quotient bits in DP (1 int + 64 frac)
  localparam int QW_SP   = 32;   // raw quotient bits in SP
  localparam int RW      = 56;   // partial remainder: sign, 3 int, 52 frac
  localparam int MW      = 53;   // mantissa width including hidden one
  localparam int EW      = 11;   // biased exponent width
  localparam int XW      = 13;   // exponent difference width
  localparam int OW      = 64;   // quotient output width
  localparam int RRW     = 128;  // remainder output width
  localparam int CW      = 7;    // iteration counter, must hold QW
  localparam int BIAS_DP = 1023;
  localparam int BIAS_SP = 127;
  localparam int ULP_DP  = 11;
  localparam int ULP_SP  = 40;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_INIT = 3'd1;
  localparam logic [2:0] ST_ITER = 3'd2;
  localparam logic [2:0] ST_POST = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // One candidate set handed to the rounder: truncated, -ulp, +ulp.
  typedef struct packed {
    logic [OW-1:0] q;
    logic [OW-1:0] qm;
    logic [OW-1:0] qp;
  } qset_t;

  function automatic logic [XW-1:0] exp_bias(input logic p);
    return p ? XW'(BIAS_SP) : XW'(BIAS_DP);
  endfunction

  // Builds a candidate set; the +/- ulp wrap modulo 2^64 (carry out dropped).
  function automatic qset_t make_qset(input logic [OW-1:0] q, input logic p);
    qset_t         s;
    logic [OW-1:0] ulp;
    ulp  = p ? (OW'(1) << ULP_SP) : (OW'(1) << ULP_DP);
    s.q  = q;
    s.qm = q - ulp;
    s.qp = q + ulp;
    return s;
  endfunction

endpackage

// File: rtl/divsqrt_qgen_if.sv
// divsqrt_qgen_if: operand launch and result bundle between the divide
// front end (master) and the quotient generator (slave).
interface divsqrt_qgen_if;
  import fpdiv_pkg::*;

  logic           start;
  logic           P;
  logic           SignA;
  logic           SignB;
  logic [EW-1:0]  ExpA;
  logic [EW-1:0]  ExpB;
  logic [MW-1:0]  MantA;
  logic [MW-1:0]  MantB;

  logic           busy;
  logic           done;
  logic [OW-1:0]  q1;
  logic [OW-1:0]  qm1;
  logic [OW-1:0]  qp1;
  logic [OW-1:0]  q0;
  logic [OW-1:0]  qm0;
  logic [OW-1:0]  qp0;
  logic [RRW-1:0] regr_out;
  logic [XW-1:0]  exp_diff;
  logic           SignR;

  modport master (
    output start, P, SignA, SignB, ExpA, ExpB, MantA, MantB,
    input  busy, done, q1, qm1, qp1, q0, qm0, qp0, regr_out, exp_diff, SignR
  );

  modport slave (
    input  start, P, SignA, SignB, ExpA, ExpB, MantA, MantB,
    output busy, done, q1, qm1, qp1, q0, qm0, qp0, regr_out, exp_diff, SignR
  );

endinterface

// File: rtl/nrdiv_step.sv
// nrdiv_step: one radix-2 non-restoring step. With first=1 the remainder is
// not doubled and a subtract is forced, which gives the initial R=A-B.
module nrdiv_step
  import fpdiv_pkg::*;
(
  input  logic [RW-1:0] r_in,
  input  logic [RW-1:0] b,
  input  logic          first,
  output logic [RW-1:0] r_out,
  output logic          q_bit
);

  logic [RW-1:0] r_sh;
  logic          sub;

  // Shift, pick add/subtract from the incoming sign, derive the quotient bit.
  always_comb begin
    r_sh  = first ? r_in : {r_in[RW-2:0], 1'b0};
    sub   = first | ~r_in[RW-1];
    r_out = sub ? (r_sh - b) : (r_sh + b);
    q_bit = ~r_out[RW-1];
  end

endmodule

// File: rtl/divsqrt_qgen.sv
// divsqrt_qgen: iterative radix-2 non-restoring mantissa divider. Produces
// one quotient bit per cycle, then the q1/q0 candidate sets, the corrected
// remainder, the biased exponent difference and the result sign.
module divsqrt_qgen
  import fpdiv_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  divsqrt_qgen_if.slave bus
);

  logic [2:0]     state_q, state_d;
  logic           p_q, p_d;
  logic [MW-1:0]  a_q, a_d;
  logic [MW-1:0]  b_q, b_d;
  logic [RW-1:0]  rem_q, rem_d;
  logic [QW-1:0]  raw_q, raw_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  qset_t          q1set_q, q1set_d;
  qset_t          q0set_q, q0set_d;
  logic [RRW-1:0] regr_q, regr_d;
  logic [XW-1:0]  exp_diff_q, exp_diff_d;
  logic           sign_r_q, sign_r_d;

  logic [RW-1:0]  b_ext;
  logic [RW-1:0]  step_r_in;
  logic [RW-1:0]  step_r_out;
  logic           step_first;
  logic           step_qbit;
  logic [RW-1:0]  rem_fix;
  logic [RRW-1:0] regr_ext;
  logic [CW-1:0]  raw_idx;
  logic [CW-1:0]  iter_limit;

  // The single step unit serves INIT (R=A-B) and every ITER cycle.
  assign b_ext      = RW'(b_q);
  assign step_first = (state_q == ST_INIT);
  assign step_r_in  = step_first ? RW'(a_q) : rem_q;

  nrdiv_step u_step (
    .r_in  (step_r_in),
    .b     (b_ext),
    .first (step_first),
    .r_out (step_r_out),
    .q_bit (step_qbit)
  );

  // Quotient bits already equal the truncated quotient; only R needs fixing.
  assign rem_fix    = rem_q[RW-1] ? (rem_q + b_ext) : rem_q;
  assign regr_ext   = {{(RRW-RW){rem_fix[RW-1]}}, rem_fix};
  assign raw_idx    = CW'(QW - 1) - cnt_q;
  assign iter_limit = p_q ? CW'(QW_SP) : CW'(QW);

  // Next-state and datapath update for IDLE/INIT/ITER/POST/DONE.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d    = state_q;
    p_d        = p_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_d      = rem_q;
    raw_d      = raw_q;
    cnt_d      = cnt_q;
    q1set_d    = q1set_q;
    q0set_d    = q0set_q;
    regr_d     = regr_q;
    exp_diff_d = exp_diff_q;
    sign_r_d   = sign_r_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_INIT;
          p_d        = bus.P;
          a_d        = bus.MantA;
          b_d        = bus.MantB;
          exp_diff_d = {2'b00, bus.ExpA} - {2'b00, bus.ExpB} + exp_bias(bus.P);
          sign_r_d   = bus.SignA ^ bus.SignB;
        end
      end
      ST_INIT: begin
        rem_d         = step_r_out;
        raw_d         = '0;
        raw_d[QW-1]   = step_qbit;
        cnt_d         = CW'(1);
        state_d       = ST_ITER;
      end
      ST_ITER: begin
        rem_d          = step_r_out;
        raw_d[raw_idx] = step_qbit;
        cnt_d          = cnt_q + CW'(1);
        if (cnt_d == iter_limit) begin
          state_d = ST_POST;
        end
      end
      ST_POST: begin
        rem_d   = rem_fix;
        q1set_d = make_qset(raw_q[QW-1:1], p_q);
        q0set_d = make_qset(raw_q[QW-2:0], p_q);
        regr_d  = p_q ? (regr_ext << (QW - QW_SP)) : regr_ext;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears every output-visible value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      p_q        <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      raw_q      <= '0;
      cnt_q      <= '0;
      q1set_q    <= '0;
      q0set_q    <= '0;
      regr_q     <= '0;
      exp_diff_q <= '0;
      sign_r_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q    <= state_d;
      p_q        <= p_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rem_q      <= rem_d;
      raw_q      <= raw_d;
      cnt_q      <= cnt_d;
      q1set_q    <= q1set_d;
      q0set_q    <= q0set_d;
      regr_q     <= regr_d;
      exp_diff_q <= exp_diff_d;
      sign_r_q   <= sign_r_d;
    end
  end

  assign bus.busy     = (state_q == ST_INIT) || (state_q == ST_ITER) || (state_q == ST_POST);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.q1       = q1set_q.q;
  assign bus.qm1      = q1set_q.qm;
  assign bus.qp1      = q1set_q.qp;
  assign bus.q0       = q0set_q.q;
  assign bus.qm0      = q0set_q.qm;
  assign bus.qp0      = q0set_q.qp;
  assign bus.regr_out = regr_q;
  assign bus.exp_diff = exp_diff_q;
  assign bus.SignR    = sign_r_q;

endmodule

// File: tb/tb_divsqrt_qgen.sv
// tb_divsqrt_qgen: directed vector table, start/reset corner sequences and
// random operands checked against an integer-division reference model.
module tb_divsqrt_qgen;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  divsqrt_qgen_if bus ();

  divsqrt_qgen dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic         p;
    logic         sa;
    logic         sb;
    logic [10:0]  ea;
    logic [10:0]  eb;
    logic [52:0]  ma;
    logic [52:0]  mb;
    logic [63:0]  q1;
    logic [63:0]  q0;
    logic [127:0] regr;
    logic [12:0]  ed;
    logic         sr;
    int           lat;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Golden model: truncated quotient of A*2^k/B and its remainder, k = 64 (DP) or 31 (SP).
  function automatic void model(input logic p, input logic [52:0] ma, input logic [52:0] mb,
                                output logic [63:0] q1, output logic [63:0] q0,
                                output logic [127:0] regr);
    logic [127:0] num;
    logic [127:0] quo;
    logic [127:0] rem;
    logic [64:0]  raw;
    int           k;
    k    = p ? 31 : 64;
    num  = 128'(ma) << k;
    quo  = num / 128'(mb);
    rem  = num - quo * 128'(mb);
    raw  = 65'(quo) << (64 - k);
    regr = rem << (64 - k);
    q1   = raw[64:1];
    q0   = raw[63:0];
  endfunction

  task automatic drive(input vec_t v);
    bus.P     = v.p;
    bus.SignA = v.sa;
    bus.SignB = v.sb;
    bus.ExpA  = v.ea;
    bus.ExpB  = v.eb;
    bus.MantA = v.ma;
    bus.MantB = v.mb;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"},     128'(bus.busy),     128'(0));
    check({tag, " done"},     128'(bus.done),     128'(0));
    check({tag, " q1"},       128'(bus.q1),       128'(0));
    check({tag, " qm1"},      128'(bus.qm1),      128'(0));
    check({tag, " qp1"},      128'(bus.qp1),      128'(0));
    check({tag, " q0"},       128'(bus.q0),       128'(0));
    check({tag, " qm0"},      128'(bus.qm0),      128'(0));
    check({tag, " qp0"},      128'(bus.qp0),      128'(0));
    check({tag, " regr"},     bus.regr_out,       128'(0));
    check({tag, " exp_diff"}, 128'(bus.exp_diff), 128'(0));
    check({tag, " sign_r"},   128'(bus.SignR),    128'(0));
  endtask

  task automatic check_result(input string tag, input vec_t v);
    logic [63:0] ulp;
    logic [63:0] e_qp1, e_qm1, e_qp0, e_qm0;
    ulp   = v.p ? 64'h0000_0100_0000_0000 : 64'h0000_0000_0000_0800;
    e_qp1 = v.q1 + ulp;
    e_qm1 = v.q1 - ulp;
    e_qp0 = v.q0 + ulp;
    e_qm0 = v.q0 - ulp;
    check({tag, " q1"},       128'(bus.q1),       128'(v.q1));
    check({tag, " qp1"},      128'(bus.qp1),      128'(e_qp1));
    check({tag, " qm1"},      128'(bus.qm1),      128'(e_qm1));
    check({tag, " q0"},       128'(bus.q0),       128'(v.q0));
    check({tag, " qp0"},      128'(bus.qp0),      128'(e_qp0));
    check({tag, " qm0"},      128'(bus.qm0),      128'(e_qm0));
    check({tag, " regr"},     bus.regr_out,       v.regr);
    check({tag, " regr_msb"}, 128'(bus.regr_out[127]), 128'(0));
    check({tag, " exp_diff"}, 128'(bus.exp_diff), 128'(v.ed));
    check({tag, " sign_r"},   128'(bus.SignR),    128'(v.sr));
  endtask

  // Launch from an IDLE cycle; lat counts cycles from the launch cycle to done (-1 on timeout).
  task automatic run_op(input vec_t v, output int lat, output logic busy_ok);
    drive(v);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat     = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_and_check(input string tag, input vec_t v);
    int   lat;
    logic busy_ok;
    run_op(v, lat, busy_ok);
    check({tag, " latency"}, 128'(lat), 128'(v.lat));
    check({tag, " busy"},    128'(busy_ok), 128'(1));
    if (lat > 0) check_result(tag, v);
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 128'(bus.done), 128'(0));
    check({tag, " hold_q1"},    128'(bus.q1),   128'(v.q1));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   n_done, first_done, second_done, tmp;
    logic saw_done;
    logic [63:0] r64;

    n_checks = 0;
    n_err    = 0;

    vecs[0] = '{p:1'b0, sa:1'b0, sb:1'b0, ea:11'd1023, eb:11'd1023,
                ma:53'h18000000000000, mb:53'h10000000000000,
                q1:64'hC000_0000_0000_0000, q0:64'h8000_0000_0000_0000,
                regr:128'd0, ed:13'd1023, sr:1'b0, lat:67};
    vecs[1] = '{p:1'b0, sa:1'b1, sb:1'b0, ea:11'd1000, eb:11'd1030,
                ma:53'h10000000000000, mb:53'h18000000000000,
                q1:64'h5555_5555_5555_5555, q0:64'hAAAA_AAAA_AAAA_AAAA,
                regr:(128'd1 << 52), ed:13'd993, sr:1'b1, lat:67};
    vecs[2] = '{p:1'b1, sa:1'b0, sb:1'b1, ea:11'd127, eb:11'd127,
                ma:53'h10000000000000, mb:53'h18000000000000,
                q1:64'h5555_5555_0000_0000, q0:64'hAAAA_AAAA_0000_0000,
                regr:(128'd1 << 84), ed:13'd127, sr:1'b1, lat:34};
    vecs[3] = '{p:1'b0, sa:1'b1, sb:1'b1, ea:11'h7FE, eb:11'd1,
                ma:53'h1ABCDEF0123456, mb:53'h1ABCDEF0123456,
                q1:64'h8000_0000_0000_0000, q0:64'h0,
                regr:128'd0, ed:13'd3068, sr:1'b0, lat:67};
    vecs[4] = '{p:1'b1, sa:1'b0, sb:1'b1, ea:11'd1, eb:11'd254,
                ma:53'h1F0F0F0F0F0F0F, mb:53'h1F0F0F0F0F0F0F,
                q1:64'h8000_0000_0000_0000, q0:64'h0,
                regr:128'd0, ed:13'h1F82, sr:1'b1, lat:34};

    // Reset state
    reset_n   = 1'b0;
    bus.start = 1'b0;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i]);
    end

    // start held high through busy and DONE; P and operands change mid-flight
    drive(vecs[0]);
    bus.start = 1'b1;
    @(posedge clk); #1;
    drive(vecs[2]);
    n_done      = 0;
    first_done  = -1;
    second_done = -1;
    for (int k = 1; k <= 110; k++) begin
      if (bus.done) begin
        n_done++;
        if (n_done == 1) begin
          first_done = k;
          check_result("t4 first", vecs[0]);
        end else if (n_done == 2) begin
          second_done = k;
          check_result("t4 second", vecs[2]);
        end
      end
      if (k == 68) check("t4 idle_after_done", 128'(bus.busy), 128'(0));
      if (k == 69) begin
        check("t4 reaccept", 128'(bus.busy), 128'(1));
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("t4 done_count",  128'(n_done),      128'(2));
    check("t4 first_done",  128'(first_done),  128'(67));
    check("t4 second_done", 128'(second_done), 128'(102));

    // Reset dropped in ITER cycle 20
    drive(vecs[0]);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    check("t5 busy_before_reset", 128'(bus.busy), 128'(1));
    reset_n = 1'b0;
    #1;
    check_zero("t5 reset");
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    if (bus.done) saw_done = 1'b1;
    check("t5 no_done", 128'(saw_done), 128'(0));
    run_and_check("t5 rerun", vecs[1]);

    // Random normalized operands, DP and SP
    for (int i = 0; i < 300; i++) begin
      r64  = {$urandom(), $urandom()};
      v.p  = 1'($urandom_range(0, 1));
      v.sa = 1'($urandom_range(0, 1));
      v.sb = 1'($urandom_range(0, 1));
      v.ea = 11'($urandom_range(0, 2047));
      v.eb = 11'($urandom_range(0, 2047));
      v.ma = {1'b1, r64[51:0]};
      r64  = {$urandom(), $urandom()};
      v.mb = (i % 20 == 0) ? v.ma : {1'b1, r64[51:0]};
      model(v.p, v.ma, v.mb, v.q1, v.q0, v.regr);
      tmp  = int'(v.ea) - int'(v.eb) + (v.p ? 127 : 1023);
      v.ed = 13'(tmp);
      v.sr = v.sa ^ v.sb;
      v.lat = v.p ? 34 : 67;
      run_and_check($sformatf("rand%0d", i), v);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
